// File: rtl/srl_sra_iter.sv
// srl_sra_iter: multi-cycle right shifter (srl/sra) for the execute stage.
// Shifts a WIDTH-bit operand right by up to 2**SHAMT_W-1 bits, STEP bits per
// cycle, under a start/ready/done handshake.
// Optional feature: define SRL_SRA_ROTATE_EN to add a "rotate" input that
// selects rotate-right (takes priority over arith).
module srl_sra_iter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5,
   parameter int unsigned STEP    = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
`ifdef SRL_SRA_ROTATE_EN
   input  logic               rotate,
`endif
   output logic               ready,
   output logic               done,
   output logic [WIDTH-1:0]   data_out
);

   // One extra bit so STEP is representable even when it exceeds the largest shamt
   localparam logic [SHAMT_W:0] STEP_X = (SHAMT_W+1)'(STEP);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic               fill_q, fill_d;
   logic               rot_q, rot_d;
   logic [SHAMT_W:0]   step_n;
   logic [WIDTH-1:0]   shifted;
   logic               rot_in;

`ifdef SRL_SRA_ROTATE_EN
   assign rot_in = rotate;
`else
   assign rot_in = 1'b0;
`endif

   // Shift datapath: move min(STEP, rem) bits, one bit position per loop pass
   always_comb begin
      step_n  = ({1'b0, rem_q} > STEP_X) ? STEP_X : {1'b0, rem_q};
      shifted = opnd_q;
      for (int i = 0; i < int'(STEP); i++) begin
         if ((SHAMT_W+1)'(i) < step_n) begin
            // Rotate recirculates the LSB; otherwise the latched fill bit enters
            shifted = {(rot_q ? shifted[0] : fill_q), shifted[WIDTH-1:1]};
         end
      end
   end

   // Next-state logic: capture on accepted start, iterate, publish result on DONE entry
   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      rem_d   = rem_q;
      fill_d  = fill_q;
      rot_d   = rot_q;
      dout_d  = dout_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               opnd_d = data_in;
               rem_d  = shamt;
               // Fill bit is fixed at accept time: the operand MSB for sra, zero for srl
               fill_d = arith & data_in[WIDTH-1];
               rot_d  = rot_in;
               if (shamt == '0) begin
                  state_d = StDone;
                  dout_d  = data_in;
               end else begin
                  state_d = StShift;
               end
            end
         end
         StShift: begin
            opnd_d = shifted;
            rem_d  = rem_q - step_n[SHAMT_W-1:0];
            if ({1'b0, rem_q} <= STEP_X) begin
               state_d = StDone;
               dout_d  = shifted;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         opnd_q  <= '0;
         dout_q  <= '0;
         rem_q   <= '0;
         fill_q  <= 1'b0;
         rot_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opnd_q  <= opnd_d;
         dout_q  <= dout_d;
         rem_q   <= rem_d;
         fill_q  <= fill_d;
         rot_q   <= rot_d;
      end
   end

   assign ready    = (state_q == StIdle);
   assign done     = (state_q == StDone);
   assign data_out = dout_q;

endmodule

// File: tb/tb_srl_sra_iter.sv
// Self-checking bench for srl_sra_iter (WIDTH=32, SHAMT_W=5, STEP=2).
// Behavioural model predicts ready/done/data_out every cycle; literal
// transactions pin the model. Rotate checks run when SRL_SRA_ROTATE_EN is defined.
module tb_srl_sra_iter;

   localparam int STEP = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] data_in = '0;
   logic [4:0]  shamt = '0;
   logic        arith = 1'b0;
   logic        rot = 1'b0;
   logic        ready, done;
   logic [31:0] data_out;

   int n_cmp = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   // Model state
   bit          m_idle = 1'b1;
   bit          m_done = 1'b0;
   int          m_left = 0;
   logic [31:0] m_res = '0;
   logic [31:0] m_dout = '0;

   srl_sra_iter #(.WIDTH(32), .SHAMT_W(5), .STEP(STEP)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .data_in  (data_in),
      .shamt    (shamt),
      .arith    (arith),
`ifdef SRL_SRA_ROTATE_EN
      .rotate   (rot),
`endif
      .ready    (ready),
      .done     (done),
      .data_out (data_out)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ref_fn(logic [31:0] d, int s, bit a, bit r);
      logic signed [31:0] sd;
      sd = d;
      if (r) return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
      if (a) return sd >>> s;
      return d >> s;
   endfunction

   // Model: result appears ceil(shamt/STEP) edges after the accepting edge, lasts one cycle
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_idle = 1'b1;
         m_done = 1'b0;
         m_left = 0;
         m_dout = '0;
      end else if (m_done) begin
         m_done = 1'b0;
         m_idle = 1'b1;
      end else if (!m_idle) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_dout = m_res;
         end
      end else if (start) begin
         m_idle = 1'b0;
         m_res  = ref_fn(data_in, int'(shamt), arith, rot);
         m_left = (int'(shamt) + STEP - 1) / STEP;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_dout = m_res;
         end
      end
   end

   // Per-cycle compare against the model
   always @(negedge clock) begin
      if (check_en) begin
         n_cmp++;
         if (ready !== m_idle || done !== m_done || data_out !== m_dout) begin
            n_fail++;
            $display("FAIL cycle t=%0t: got ready=%0b done=%0b data_out=%h, required ready=%0b done=%0b data_out=%h",
                     $time, ready, done, data_out, m_idle, m_done, m_dout);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // One transaction with literal expectations; spec edge 1 = first negedge after accept
   task automatic run_lit(input logic [31:0] d, input int s, input bit a, input bit r,
                          input logic [31:0] exp_v, input int exp_e, input string name);
      int k;
      int guard;
      bit rdy_seen;
      guard = 0;
      while (!ready && guard < 100) begin
         @(negedge clock);
         guard++;
      end
      chk({name, " ready before start"}, {31'b0, ready}, 32'd1);
      start = 1'b1; data_in = d; shamt = s[4:0]; arith = a; rot = r;
      @(negedge clock);
      start = 1'b0; data_in = $urandom; shamt = 5'($urandom); arith = ~a; rot = ~r;
      k = 1;
      rdy_seen = 1'b0;
      while (!done && k < 40) begin
         if (ready) rdy_seen = 1'b1;
         @(negedge clock);
         k++;
      end
      chk({name, " done edge"}, k, exp_e);
      chk({name, " data_out"}, data_out, exp_v);
      chk({name, " ready low while busy"}, {31'b0, rdy_seen | ready}, 32'd0);
      @(negedge clock);
      chk({name, " single pulse/idle"}, {30'b0, done, ready}, 32'd1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int dones;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      chk("reset ready", {31'b0, ready}, 32'd1);
      chk("reset done", {31'b0, done}, 32'd0);
      chk("reset data_out", data_out, 32'h0);
      check_en = 1'b1;
      @(negedge clock);

      run_lit(32'h8000_0000, 31, 1'b1, 1'b0, 32'hFFFF_FFFF, 17, "sra31");
      run_lit(32'h8000_0000, 4, 1'b0, 1'b0, 32'h0800_0000, 3, "srl4");
      run_lit(32'h7FFF_FFF0, 4, 1'b1, 1'b0, 32'h07FF_FFFF, 3, "sra4");
      run_lit(32'hDEAD_BEEF, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1, "sra0");
      run_lit(32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1, "srl0 back-to-back");
      run_lit(32'hF000_000F, 3, 1'b1, 1'b0, 32'hFE00_0001, 3, "sra3 odd");
`ifdef SRL_SRA_ROTATE_EN
      run_lit(32'h0000_0003, 2, 1'b1, 1'b1, 32'hC000_0000, 2, "rot2");
      run_lit(32'h1234_5678, 31, 1'b0, 1'b1, 32'h2468_ACF0, 17, "rot31");
`endif

      // Start while busy must be ignored
      start = 1'b1; data_in = 32'hF000_0000; shamt = 5'd8; arith = 1'b0; rot = 1'b0;
      @(negedge clock);
      data_in = 32'h1234_5678; shamt = 5'd1; arith = 1'b1;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) start = 1'b0;
         if (done) begin
            dones++;
            chk("busy-ignore data_out", data_out, 32'h00F0_0000);
         end
         @(negedge clock);
      end
      chk("busy-ignore done count", dones, 1);

      // Reset at edge 5 of a 31-bit shift
      start = 1'b1; data_in = 32'h8000_0000; shamt = 5'd31; arith = 1'b1;
      @(posedge clock);
      repeat (5) @(posedge clock);
      #2 reset_n = 1'b0;
      start = 1'b0;
      #1;
      chk("abort ready", {31'b0, ready}, 32'd1);
      chk("abort done", {31'b0, done}, 32'd0);
      chk("abort data_out", data_out, 32'h0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (done) dones++;
      end
      chk("abort no done after release", dones, 0);

      // Randomized traffic, including spurious starts while busy and one reset pulse
      for (int c = 0; c < 2000; c++) begin
         @(negedge clock);
         start   = ($urandom_range(3) == 0);
         data_in = $urandom;
         shamt   = 5'($urandom);
         arith   = 1'($urandom);
`ifdef SRL_SRA_ROTATE_EN
         rot     = 1'($urandom);
`else
         rot     = 1'b0;
`endif
         if (c == 777) begin
            #2 reset_n = 1'b0;
            @(negedge clock);
            reset_n = 1'b1;
         end
      end
      start = 1'b0;
      repeat (20) @(negedge clock);
      check_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
